instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch stage with loadable local instruction memory
//
// Purpose: holds a small program in an internal IMEM_DEPTH x 32 memory and
// streams it, one word per cycle, into a registered output stage with a
// valid/ready handshake. Fetching starts at RESET_PC on a start pulse and
// stops at the first all-zero word or after the last memory word.
//
// Ports:
//   clk          clock, rising edge
//   reset        asynchronous active-high reset (memory contents preserved)
//   load_en      memory write strobe, honoured in IDLE only
//   load_addr    memory word address for the write
//   load_data    instruction word to write
//   start        pulse: begin fetching at RESET_PC (from IDLE or HALT)
//   instr_ready  decode stage accepts instrCode this cycle
//   instrCode    registered instruction word
//   instr_valid  instrCode/pc_out hold a valid, unconsumed instruction
//   pc_out       byte address of the word in instrCode
//   busy         fetching (RUN) or waiting for the last word to drain (DRAIN)
//   halted       program finished, waiting for a restart

module instr_fetch #(
  parameter int unsigned IMEM_DEPTH = 32,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          load_en,
  input  logic [$clog2(IMEM_DEPTH)-1:0] load_addr,
  input  logic [31:0]                   load_data,
  input  logic                          start,
  input  logic                          instr_ready,
  output logic [31:0]                   instrCode,
  output logic                          instr_valid,
  output logic [31:0]                   pc_out,
  output logic                          busy,
  output logic                          halted
);

  localparam int unsigned     AW       = $clog2(IMEM_DEPTH);
  // Low two bits of the start address are dropped: fetches are word aligned.
  localparam logic [31:0]     START_PC = {RESET_PC[31:2], 2'b00};
  localparam logic [AW-1:0]   LAST_IDX = AW'(IMEM_DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic [31:0] imem [IMEM_DEPTH];

  logic [31:0] pc;
  logic [31:0] pc_next;
  // primed is cleared on every entry into RUN; the first RUN cycle only sets
  // it, so the first word is presented two edges after start. This also lets
  // a load issued together with start land before that word is read.
  logic        primed;
  logic        primed_next;
  logic [31:0] code_next;
  logic [31:0] pc_out_next;
  logic        valid_next;
  logic        mem_we;

  logic [AW-1:0] pc_idx;
  logic [31:0]   fetch_word;
  logic          advance;
  logic          at_last;

  assign pc_idx     = pc[AW+1:2];
  assign fetch_word = imem[pc_idx];
  assign at_last    = (pc_idx == LAST_IDX);
  // The output register may only be replaced when empty or being consumed.
  assign advance    = !instr_valid || instr_ready;

  assign busy   = (state == RUN) || (state == DRAIN);
  assign halted = (state == HALT);

  // Instruction memory: no reset so a program survives reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      imem[load_addr] <= load_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc          <= START_PC;
      primed      <= 1'b0;
      instrCode   <= 32'h0000_0000;
      pc_out      <= 32'h0000_0000;
      instr_valid <= 1'b0;
    end else begin
      pc          <= pc_next;
      primed      <= primed_next;
      instrCode   <= code_next;
      pc_out      <= pc_out_next;
      instr_valid <= valid_next;
    end
  end

  always_comb begin
    state_next  = state;
    pc_next     = pc;
    primed_next = primed;
    code_next   = instrCode;
    pc_out_next = pc_out;
    valid_next  = instr_valid;
    mem_we      = 1'b0;

    unique case (state)
      IDLE: begin
        mem_we = load_en;
        if (start) begin
          state_next  = RUN;
          pc_next     = START_PC;
          primed_next = 1'b0;
        end
      end

      RUN: begin
        if (!primed) begin
          primed_next = 1'b1;
        end else if (advance) begin
          if (fetch_word == 32'h0000_0000) begin
            // End marker: never presented.
            valid_next = 1'b0;
            state_next = HALT;
          end else begin
            code_next   = fetch_word;
            pc_out_next = pc;
            valid_next  = 1'b1;
            pc_next     = pc + 32'd4;
            if (at_last) begin
              // Last word presented; no wrap back to address 0.
              state_next = DRAIN;
            end
          end
        end
      end

      DRAIN: begin
        if (instr_valid && instr_ready) begin
          valid_next = 1'b0;
          state_next = HALT;
        end
      end

      HALT: begin
        if (start) begin
          state_next  = RUN;
          pc_next     = START_PC;
          primed_next = 1'b0;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
